uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: valid/ready byte intake, LSB-first serialisation,
// optional even/odd parity, one or two stop bits, and an end-of-frame done pulse.
module uart_tx #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    // A baud rate above the clock rate degenerates to one clock per bit.
    localparam int unsigned BIT_CYCLES = (CLK_FREQ / BAUD > 0) ? CLK_FREQ / BAUD : 1;
    localparam int unsigned CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned STOP_N     = (STOP_BITS == 2) ? 2 : 1;
    localparam int unsigned PRE_END    = (BIT_CYCLES >= 2) ? BIT_CYCLES - 2 : 0;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(PRE_END);
    localparam logic             STOP_LAST = 1'(STOP_N - 1);
    localparam logic             ODD       = 1'(PARITY_ODD != 0);
    localparam logic             HAS_PAR   = 1'(PARITY_EN != 0);
    localparam logic             SHORT_BIT = 1'(BIT_CYCLES == 1);
    localparam logic             ONE_STOP  = 1'(STOP_N == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic             stop_idx;
    logic [7:0]       shreg;
    logic             par_bit;

    logic bit_end;
    logic last_stop;
    logic to_stop;
    logic done_next;

    // tx_done is registered, so predict when the next clock is the final stop-bit clock.
    always_comb begin
        bit_end   = (cnt == CNT_LAST);
        last_stop = (stop_idx == STOP_LAST);
        to_stop   = 1'b0;
        done_next = 1'b0;
        if (bit_end) begin
            if (state == S_PARITY) begin
                to_stop = 1'b1;
            end else if (state == S_DATA && bit_idx == 3'd7 && !HAS_PAR) begin
                to_stop = 1'b1;
            end
        end
        if (state == S_STOP) begin
            if (!bit_end) begin
                done_next = last_stop && !SHORT_BIT && (cnt == CNT_PRE);
            end else begin
                done_next = !last_stop && SHORT_BIT;
            end
        end else if (to_stop) begin
            done_next = SHORT_BIT && ONE_STOP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            tx       <= 1'b1;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            tx_done <= done_next;
            case (state)
                S_IDLE: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    cnt     <= '0;
                    if (tx_valid && tx_ready) begin
                        shreg    <= tx_data;
                        par_bit  <= (^tx_data) ^ ODD;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        tx       <= 1'b0;
                        tx_ready <= 1'b0;
                        tx_busy  <= 1'b1;
                        state    <= S_START;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        tx    <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                        state <= S_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            if (HAS_PAR) begin
                                tx    <= par_bit;
                                state <= S_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        tx    <= 1'b1;
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        cnt <= '0;
                        if (last_stop) begin
                            tx_ready <= 1'b1;
                            tx_busy  <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    tx       <= 1'b1;
                    tx_ready <= 1'b0;
                    tx_busy  <= 1'b0;
                    cnt      <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 clocks per bit: one 8N1 instance and one
// 8E2 instance, every frame clock checked against a hand-built bit sequence.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data0, data1;
    logic       valid0, valid1;
    logic       ready0, tx0, busy0, done0;
    logic       ready1, tx1, busy1, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .CLK_FREQ(1000000), .BAUD(100000), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut0 (
        .clk(clk), .rst(rst), .tx_data(data0), .tx_valid(valid0),
        .tx_ready(ready0), .tx(tx0), .tx_busy(busy0), .tx_done(done0)
    );

    uart_tx #(
        .CLK_FREQ(1000000), .BAUD(100000), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
    ) dut1 (
        .clk(clk), .rst(rst), .tx_data(data1), .tx_valid(valid1),
        .tx_ready(ready1), .tx(tx1), .tx_busy(busy1), .tx_done(done1)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge of frame clock 1; leaves at the negedge of the last frame clock.
    task automatic rx_frame(input bit sel, input logic [7:0] b, input bit par_en,
                            input logic par_val, input int n_stop, input bit poke,
                            input string tag);
        logic [11:0] seq;
        logic [7:0]  rx;
        logic        tx_o, done_o, busy_o, ready_o;
        int          nb, bi;
        seq = '1;
        seq[0] = 1'b0;
        for (int i = 0; i < 8; i++) seq[1 + i] = b[i];
        if (par_en) seq[9] = par_val;
        nb = 9 + int'(par_en) + n_stop;
        rx = '0;
        for (int k = 0; k < nb * 10; k++) begin
            if (k > 0) @(negedge clk);
            if (poke && k == 20) begin
                valid0 = 1'b1;
                data0  = 8'hF0;
            end
            if (poke && k == 40) valid0 = 1'b0;
            tx_o    = sel ? tx1 : tx0;
            done_o  = sel ? done1 : done0;
            busy_o  = sel ? busy1 : busy0;
            ready_o = sel ? ready1 : ready0;
            bi = k / 10;
            check_bit({tag, ".tx"}, tx_o, seq[bi]);
            check_bit({tag, ".done"}, done_o, 1'(k == nb * 10 - 1));
            check_bit({tag, ".busy"}, busy_o, 1'b1);
            check_bit({tag, ".ready"}, ready_o, 1'b0);
            if (bi >= 1 && bi <= 8 && (k % 10) == 5) rx[bi - 1] = tx_o;
        end
        check_byte({tag, ".rxbyte"}, rx, b);
    endtask

    task automatic check_idle0(input string tag);
        check_bit({tag, ".idle_tx"}, tx0, 1'b1);
        check_bit({tag, ".idle_ready"}, ready0, 1'b1);
        check_bit({tag, ".idle_busy"}, busy0, 1'b0);
        check_bit({tag, ".idle_done"}, done0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        valid0 = 1'b0;
        valid1 = 1'b0;
        data0 = 8'h00;
        data1 = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("rst.tx0", tx0, 1'b1);
        check_bit("rst.ready0", ready0, 1'b0);
        check_bit("rst.busy0", busy0, 1'b0);
        check_bit("rst.done0", done0, 1'b0);
        check_bit("rst.tx1", tx1, 1'b1);
        check_bit("rst.ready1", ready1, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_bit("rel.ready0", ready0, 1'b1);
        check_bit("rel.ready1", ready1, 1'b1);
        check_bit("rel.tx0", tx0, 1'b1);

        // Single 0x55, 8N1; tx_data scrambled right after the handshake.
        valid0 = 1'b1;
        data0  = 8'h55;
        @(negedge clk);
        valid0 = 1'b0;
        data0  = 8'h00;
        rx_frame(1'b0, 8'h55, 1'b0, 1'b0, 1, 1'b0, "b55");
        @(negedge clk);
        check_idle0("b55");

        // 0xA3 with even parity (popcount 4 -> 0) and two stop bits: 120 clocks.
        valid1 = 1'b1;
        data1  = 8'hA3;
        @(negedge clk);
        valid1 = 1'b0;
        data1  = 8'hFF;
        rx_frame(1'b1, 8'hA3, 1'b1, 1'b0, 2, 1'b0, "bA3");
        @(negedge clk);
        check_bit("bA3.idle_tx", tx1, 1'b1);
        check_bit("bA3.idle_ready", ready1, 1'b1);
        check_bit("bA3.idle_busy", busy1, 1'b0);
        check_bit("bA3.idle_done", done1, 1'b0);

        // Back-to-back 0x01 then 0xFF with tx_valid held high.
        valid0 = 1'b1;
        data0  = 8'h01;
        @(negedge clk);
        data0 = 8'hFF;
        rx_frame(1'b0, 8'h01, 1'b0, 1'b0, 1, 1'b0, "b2b01");
        @(negedge clk);
        check_idle0("b2b_gap");
        @(negedge clk);
        valid0 = 1'b0;
        rx_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1, 1'b0, "b2bFF");
        @(negedge clk);
        check_idle0("b2bFF");

        // 0x0F with 0xF0 offered during DATA: must be ignored.
        valid0 = 1'b1;
        data0  = 8'h0F;
        @(negedge clk);
        valid0 = 1'b0;
        data0  = 8'hF0;
        rx_frame(1'b0, 8'h0F, 1'b0, 1'b0, 1, 1'b1, "b0F");
        @(negedge clk);
        check_idle0("b0F");
        for (int i = 0; i < 5; i++) begin
            repeat (4) @(negedge clk);
            check_bit("b0F.no_second_tx", tx0, 1'b1);
            check_bit("b0F.no_second_busy", busy0, 1'b0);
        end

        // Reset at frame clock 45 of 0x96 (bit on line there is d3 = 0).
        valid0 = 1'b1;
        data0  = 8'h96;
        @(negedge clk);
        valid0 = 1'b0;
        repeat (44) @(negedge clk);
        check_bit("abort.tx_before", tx0, 1'b0);
        check_bit("abort.busy_before", busy0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_bit("abort.tx", tx0, 1'b1);
        check_bit("abort.busy", busy0, 1'b0);
        check_bit("abort.done", done0, 1'b0);
        check_bit("abort.ready", ready0, 1'b0);
        @(negedge clk);
        check_idle0("abort_rel");
        for (int i = 0; i < 3; i++) begin
            repeat (20) @(negedge clk);
            check_bit("abort.no_done", done0, 1'b0);
            check_bit("abort.line_high", tx0, 1'b1);
        end

        // Fresh byte after the aborted frame.
        valid0 = 1'b1;
        data0  = 8'h3C;
        @(negedge clk);
        valid0 = 1'b0;
        rx_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1, 1'b0, "b3C");
        @(negedge clk);
        check_idle0("b3C");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
